// File: rtl/fifo_pkg.sv
// Shared types and sizing for the shift-FIFO read-side unloader.
package fifo_pkg;

    localparam int unsigned DATA_W     = 64;
    localparam int unsigned FIFO_DEPTH = 8;
    localparam int unsigned BUF_DEPTH  = 4;
    localparam int unsigned CNT_W      = $clog2(FIFO_DEPTH) + 1;
    localparam int unsigned OCC_W      = $clog2(BUF_DEPTH) + 1;

    typedef logic [DATA_W-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        DRAIN,
        FLUSH,
        DONE
    } unload_state_t;

endpackage

// File: rtl/fifo_unloader_cap_buf.sv
// cap_buf: DEPTH-entry circular capture buffer with a registered head word.
//   clk, rst       clock, async active-high reset
//   push/push_data write one word at the tail
//   pop            release the head word
//   head           head word (0 while empty)
//   empty/full     occupancy flags
//   occupancy      number of stored words, 0..DEPTH
module cap_buf
    import fifo_pkg::*;
#(
    parameter int unsigned  DEPTH = BUF_DEPTH,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned OW    = PTR_W + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  word_t         push_data,
    input  logic          pop,
    output word_t         head,
    output logic          empty,
    output logic          full,
    output logic [OW-1:0] occupancy
);

    word_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    word_t            head_q, head_d;
    logic             empty_q, full_q;
    logic             do_push, do_pop;

    // Pointer/occupancy update; head is the word at the new read pointer,
    // bypassing the array when that slot is being written this edge.
    always_comb begin
        do_pop   = pop && (occ_q != '0);
        do_push  = push && ((occ_q != OW'(DEPTH)) || do_pop);
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
        occ_d    = occ_q + OW'(do_push) - OW'(do_pop);
        head_d   = '0;
        if (occ_d != '0) begin
            head_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            head_q   <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            head_q   <= head_d;
            empty_q  <= (occ_d == '0);
            full_q   <= (occ_d == OW'(DEPTH));
        end
    end

    // Storage array; contents are don't-care after reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign head      = head_q;
    assign empty     = empty_q;
    assign full      = full_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/fifo_unloader.sv
// fifo_unloader: drains a programmed number of words from a shift FIFO into a
// small capture buffer and presents them over a valid/ready read port.
//   clk, rst            clock, async active-high reset
//   start, count        drain request and word count (clamped to FIFO_DEPTH)
//   fifo_en, fifo_q     FIFO shift enable and oldest-stage word
//   rd_valid/rd_data    head of capture buffer, popped on rd_ready
//   busy, done          busy during DRAIN/FLUSH, one-cycle done pulse
//   stall_cnt           saturating stall counter, only when
//                       FIFO_UNLOADER_STATS_EN is defined
module fifo_unloader
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  count,
    output logic              fifo_en,
    input  logic [DATA_W-1:0] fifo_q,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    input  logic              rd_ready,
    output logic              busy,
    output logic              done
`ifdef FIFO_UNLOADER_STATS_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);

    unload_state_t    state_q, state_d;
    logic [CNT_W-1:0] remaining_q, remaining_d;
    logic             fifo_en_q, fifo_en_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             start_acc;

    word_t            buf_head;
    logic             buf_empty, buf_full, buf_pop, buf_room;
    logic [OCC_W-1:0] buf_occ, occ_nxt;

    cap_buf #(.DEPTH(BUF_DEPTH)) u_cap_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_en_q),
        .push_data (fifo_q),
        .pop       (buf_pop),
        .head      (buf_head),
        .empty     (buf_empty),
        .full      (buf_full),
        .occupancy (buf_occ)
    );

    assign buf_pop = !buf_empty && rd_ready;

    // Occupancy after this edge; fifo_en for the next cycle is granted only
    // if a slot is already free then, so the push can never overflow.
    always_comb begin
        occ_nxt  = buf_occ + OCC_W'(fifo_en_q) - OCC_W'(buf_pop);
        buf_room = buf_full ? buf_pop : (occ_nxt != OCC_W'(BUF_DEPTH));
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        start_acc   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    start_acc = 1'b1;
                    if (count == '0) begin
                        state_d = DONE;
                    end else begin
                        remaining_d = (count > CNT_W'(FIFO_DEPTH)) ? CNT_W'(FIFO_DEPTH) : count;
                        state_d     = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (fifo_en_q) begin
                    remaining_d = remaining_q - CNT_W'(1);
                end
                if (remaining_d == '0) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (occ_nxt == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        fifo_en_d = (state_d == DRAIN) && (remaining_d != '0) && buf_room;
        busy_d    = (state_d == DRAIN) || (state_d == FLUSH);
        done_d    = (state_d == DONE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            remaining_q <= '0;
            fifo_en_q   <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            fifo_en_q   <= fifo_en_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign fifo_en  = fifo_en_q;
    assign rd_valid = !buf_empty;
    assign rd_data  = buf_head;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef FIFO_UNLOADER_STATS_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Saturating count of cycles where a word waits on the consumer.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (start_acc) begin
            stall_cnt_d = '0;
        end else if (rd_valid && !rd_ready && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`else
    logic unused_start_acc;
    assign unused_start_acc = start_acc;
`endif

endmodule

// File: tb/tb_fifo_unloader.sv
// Bench for fifo_unloader: models the attached shift FIFO as an array read at
// a moving index, records every handshaken word, and checks each drain
// against the first min(count, FIFO_DEPTH) words the FIFO held.
module tb_fifo_unloader;
    import fifo_pkg::*;

    logic              clk = 1'b0;
    logic              rst, start, rd_ready;
    logic [CNT_W-1:0]  count;
    logic              fifo_en, rd_valid, busy, done;
    logic [DATA_W-1:0] fifo_q, rd_data;
`ifdef FIFO_UNLOADER_STATS_EN
    logic [31:0]       stall_cnt;
`endif

    fifo_unloader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .count    (count),
        .fifo_en  (fifo_en),
        .fifo_q   (fifo_q),
        .rd_valid (rd_valid),
        .rd_data  (rd_data),
        .rd_ready (rd_ready),
        .busy     (busy),
        .done     (done)
`ifdef FIFO_UNLOADER_STATS_EN
        ,
        .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Shift FIFO model: q is the word at idx, each en cycle advances by one.
    logic [63:0] mem [16];
    int          idx = 0;
    logic        reload = 1'b0;
    logic [63:0] spec_w [8] = '{64'd1, -64'sd8, -64'sd3, 64'd16457, 64'd89320567,
                                64'd58947128924718, -64'sd123567, 64'd55};

    always @(posedge clk or posedge reload) begin
        if (reload) idx <= 0;
        else if (fifo_en && idx < 15) idx <= idx + 1;
    end
    assign fifo_q = mem[idx];

    // Monitor: handshaken words, en pulses, done pulses, stability, occupancy.
    logic [63:0] got [$];
    int          en_cnt = 0, done_cnt = 0, busy_err = 0, stab_err = 0;
    int          occ_m = 0, occ_max = 0, en_run = 0, en_run_max = 0;
    logic        prev_stall = 1'b0;
    logic [63:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            occ_m      = 0;
            en_run     = 0;
            prev_stall = 1'b0;
        end else begin
            if (rd_valid && rd_ready) got.push_back(rd_data);
            if (prev_stall && rd_data !== prev_data) stab_err++;
            prev_stall = rd_valid && !rd_ready;
            prev_data  = rd_data;
            if (fifo_en) begin
                en_cnt++;
                en_run++;
                if (en_run > en_run_max) en_run_max = en_run;
            end else begin
                en_run = 0;
            end
            if (done) begin
                done_cnt++;
                if (busy) busy_err++;
            end
            occ_m = occ_m + (fifo_en ? 1 : 0) - ((rd_valid && rd_ready) ? 1 : 0);
            if (occ_m > occ_max) occ_max = occ_m;
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_fifo(input bit use_spec);
        for (int k = 0; k < 16; k++) mem[k] = {$urandom, $urandom};
        if (use_spec) for (int k = 0; k < 8; k++) mem[k] = spec_w[k];
        reload = 1'b1;
        #1 reload = 1'b0;
    endtask

    task automatic start_cmd(input int n);
        @(posedge clk); #1;
        start = 1'b1;
        count = CNT_W'(n);
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int mode, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
            rd_ready = (mode == 0) ? 1'b1 : 1'(($urandom % 3) != 0);
        end
    endtask

    task automatic finish_run(input string tag, input int n, input int mode,
                              input int e0, input int g0, input int d0);
        int nexp;
        bit ok;
        nexp = (n > 8) ? 8 : n;
        wait_done(mode, ok);
        chk($sformatf("%s_done_seen", tag), 64'(ok), 64'd1);
        @(posedge clk); #1;
        rd_ready = 1'b0;
        @(negedge clk); #1;
        chk($sformatf("%s_en_pulses", tag), 64'(en_cnt - e0), 64'(nexp));
        chk($sformatf("%s_done_pulses", tag), 64'(done_cnt - d0), 64'd1);
        chk($sformatf("%s_words", tag), 64'(got.size() - g0), 64'(nexp));
        for (int k = 0; k < nexp && (g0 + k) < got.size(); k++)
            chk($sformatf("%s_word%0d", tag, k), got[g0 + k], mem[k]);
        chk($sformatf("%s_busy_after", tag), 64'(busy), 64'd0);
        chk($sformatf("%s_valid_after", tag), 64'(rd_valid), 64'd0);
    endtask

    task automatic snap(output int e0, output int g0, output int d0);
        e0 = en_cnt;
        g0 = got.size();
        d0 = done_cnt;
    endtask

    initial begin
        int e0, g0, d0, c, n;
        bit seen;
        rst = 1'b1; start = 1'b0; count = '0; rd_ready = 1'b0;
        load_fifo(1'b1);

        // Reset state
        @(negedge clk);
        chk("rst_fifo_en", 64'(fifo_en), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_rd_data", rd_data, 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Basic drain, consumer always ready
        rd_ready = 1'b1;
        snap(e0, g0, d0);
        start_cmd(8);
        @(negedge clk);
        chk("basic_busy", 64'(busy), 64'd1);
        finish_run("basic", 8, 0, e0, g0, d0);
        chk("basic_en_consecutive", 64'(en_run_max), 64'd8);

        // Backpressure: four pulses then stall with head word held
        load_fifo(1'b1);
        snap(e0, g0, d0);
        start_cmd(8);
        repeat (12) @(negedge clk);
        #1;
        chk("bp_en_pulses_stalled", 64'(en_cnt - e0), 64'd4);
        chk("bp_valid", 64'(rd_valid), 64'd1);
        chk("bp_head", rd_data, 64'd1);
        finish_run("bp", 8, 0, e0, g0, d0);

        // Zero count: done the cycle after start, no shifts
        snap(e0, g0, d0);
        start_cmd(0);
        @(negedge clk);
        chk("zero_done_next", 64'(done), 64'd1);
        chk("zero_busy", 64'(busy), 64'd0);
        @(negedge clk); #1;
        chk("zero_en_pulses", 64'(en_cnt - e0), 64'd0);

        // Over-range count clamps to FIFO_DEPTH
        load_fifo(1'b0);
        rd_ready = 1'b1;
        snap(e0, g0, d0);
        start_cmd(12);
        finish_run("clamp", 12, 0, e0, g0, d0);

        // Push/pop around a full buffer with alternating ready
        load_fifo(1'b0);
        snap(e0, g0, d0);
        start_cmd(8);
        repeat (6) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            rd_ready = (i % 2 == 0);
        end
        finish_run("full_toggle", 8, 0, e0, g0, d0);

        // Reset in the middle of a drain
        load_fifo(1'b0);
        start_cmd(8);
        c = 0;
        for (int i = 0; i < 50 && c < 3; i++) begin
            @(negedge clk);
            if (fifo_en) c++;
        end
        chk("mid_rst_reached_3", 64'(c), 64'd3);
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        chk("mid_rst_fifo_en", 64'(fifo_en), 64'd0);
        chk("mid_rst_valid", 64'(rd_valid), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        @(negedge clk);
        chk("mid_rst_en_held", 64'(fifo_en), 64'd0);
        @(posedge clk); #1 rst = 1'b0;
        load_fifo(1'b0);
        rd_ready = 1'b1;
        snap(e0, g0, d0);
        start_cmd(2);
        finish_run("post_rst", 2, 0, e0, g0, d0);

        // Randomized drains with random consumer
        for (int r = 0; r < 6; r++) begin
            load_fifo(1'b0);
            n = $urandom_range(0, 12);
            rd_ready = 1'(($urandom % 2) != 0);
            snap(e0, g0, d0);
            start_cmd(n);
            finish_run($sformatf("rnd%0d_n%0d", r, n), n, 1, e0, g0, d0);
        end

`ifdef FIFO_UNLOADER_STATS_EN
        // Stall counter: ten stalled cycles, then cleared by next start
        load_fifo(1'b0);
        rd_ready = 1'b0;
        snap(e0, g0, d0);
        start_cmd(2);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = rd_valid;
        end
        repeat (10) @(negedge clk);
        chk("stall_cnt_10", 64'(stall_cnt), 64'd10);
        #1 rd_ready = 1'b1;
        finish_run("stall", 2, 0, e0, g0, d0);
        chk("stall_cnt_hold", 64'(stall_cnt), 64'd10);
        load_fifo(1'b0);
        rd_ready = 1'b1;
        snap(e0, g0, d0);
        start_cmd(1);
        @(negedge clk);
        chk("stall_cnt_clear", 64'(stall_cnt), 64'd0);
        finish_run("stall_clr", 1, 0, e0, g0, d0);
`else
        seen = 1'b0;
`endif

        // Whole-run invariants
        chk("rd_data_stable", 64'(stab_err), 64'd0);
        chk("busy_low_at_done", 64'(busy_err), 64'd0);
        chk("occupancy_le_4", 64'(occ_max <= 4), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_unloader.md
Name: fifo_unloader

Overview:
- Read-side companion to the 64-bit shift-register FIFO (`clk`/`rst_n`/`en`/`d`/`q`).
- On a start command it pulses the FIFO's `en` to shift out a programmed number of words and captures each `q` word into a small local buffer.
- Captured words are presented to the MMIO read path over a valid/ready handshake.
- Sits between the FIFO's output `q` and the CCI-P MMIO read mux.

Parameters:
- DATA_W, 64, width of FIFO words and `rd_data`.
- FIFO_DEPTH, 8, number of stages in the attached shift FIFO; maximum legal drain count.
- BUF_DEPTH, 4, entries in the local capture buffer; power of two, ≥2.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous active-high reset.
- start  in  1  single-cycle drain request; accepted only in IDLE.
- count  in  $clog2(FIFO_DEPTH)+1  words to drain; sampled with start.
- fifo_en  out  1  shift enable to the FIFO's `en`.
- fifo_q  in  DATA_W  FIFO's `q` (oldest stage).
- rd_valid  out  1  `rd_data` holds an unread word.
- rd_data  out  DATA_W  head of capture buffer.
- rd_ready  in  1  consumer accepts `rd_data` this cycle.
- busy  out  1  high from start acceptance until done.
- done  out  1  one-cycle pulse when all words are drained and read out.

Behaviour:
- Reset (async, `rst`=1):
  - state=IDLE, `fifo_en`=0, `rd_valid`=0, `rd_data`=0, `busy`=0, `done`=0.
  - Buffer pointers, occupancy and remaining counter cleared; buffer contents need not be cleared.
- Reset mid-drain: all of the above takes effect immediately; no further `fifo_en`; partially captured data is discarded.
- `fifo_en` is registered. In a cycle where `fifo_en`=1, `fifo_q` is written into the buffer at the same clock edge that shifts the FIFO: capture-and-shift, zero added latency.
- States:
  - IDLE:
    - `start`=1 with `count`=0 goes straight to DONE.
    - `start`=1 with `count`>FIFO_DEPTH is clamped to FIFO_DEPTH.
    - Otherwise load `remaining`=`count` and go to DRAIN.
  - DRAIN:
    - `fifo_en`=1 in a cycle iff `remaining`>0 and buffer occupancy after this cycle's pop < BUF_DEPTH. A pop in the same cycle frees a slot, so simultaneous push/pop on a full buffer is legal.
    - Each `fifo_en` cycle decrements `remaining` and pushes one word.
    - When `remaining` reaches 0, go to FLUSH.
  - FLUSH: wait until the buffer is empty (last pop completed), then go to DONE.
  - DONE: `done`=1 for exactly one cycle, `busy`=0, then IDLE.
- `busy`=1 in DRAIN and FLUSH; 0 in IDLE and DONE.
- `start` in any state other than IDLE is ignored (no queueing).
- Read handshake:
  - `rd_valid`=(occupancy≠0).
  - Pop on `rd_valid` && `rd_ready`.
  - `rd_data` is driven from the head entry and is stable while `rd_valid`=1 and `rd_ready`=0.
  - `rd_ready` with `rd_valid`=0 has no effect.
- Pointers are $clog2(BUF_DEPTH) bits and wrap modulo BUF_DEPTH. Occupancy is $clog2(BUF_DEPTH)+1 bits and never exceeds BUF_DEPTH.
- Word order out is identical to FIFO shift-out order; no reordering or duplication.
- Throughput: 1 word/cycle sustained when `rd_ready` is held 1. Time from first `fifo_en` to first `rd_valid` is 1 cycle.

Optional Feature:
- Macro: FIFO_UNLOADER_STATS_EN.
- Defined:
  - Adds output port `stall_cnt` [31:0].
  - Increments every cycle with `rd_valid`=1 and `rd_ready`=0; saturates at 32'hFFFF_FFFF.
  - Clears on `rst` and on start acceptance.
- Undefined: the port and the counter logic are absent; all other behaviour is identical.

Decomposition:
- Package fifo_pkg:
  - `DATA_W`/`FIFO_DEPTH` localparams.
  - typedef `word_t` (logic [DATA_W-1:0]).
  - typedef enum `unload_state_t` {IDLE, DRAIN, FLUSH, DONE}.
- One natural sub-module: cap_buf, a BUF_DEPTH-entry circular buffer.
  - Ports: push, push_data, pop, head, empty, full, occupancy.
  - Async active-high reset.
- Top level holds the FSM, `remaining` counter and optional stats.

Test Plan:
- Basic drain: FIFO preloaded 1, -8, -3, 16457, 89320567, 58947128924718, -123567, 55; `start`, `count`=8, `rd_ready`=1 → `fifo_en` high 8 consecutive cycles; `rd_data` sequence matches that order exactly; `done` pulses once; `busy` falls with `done`.
- Backpressure: `count`=8, `rd_ready`=0 → `fifo_en` stops after 4 pulses and `rd_valid` holds with `rd_data`=1 stable; release `rd_ready` → remaining 4 words drain in order and `done` fires.
- Boundaries: `count`=0 → `done` next cycle, no `fifo_en`; `count`=12 → clamped, exactly 8 `fifo_en` pulses.
- Simultaneous push/pop at full: `rd_ready` toggled 1,0,1,0 while the buffer is at 4 entries → no lost or duplicated words, occupancy never exceeds 4.
- Reset mid-drain: assert `rst` after 3 `fifo_en` pulses → `fifo_en`, `rd_valid`, `busy` go 0 immediately; a later `start` with `count`=2 works normally.
- Stats (with FIFO_UNLOADER_STATS_EN): hold `rd_ready`=0 for 10 cycles with `rd_valid`=1 → `stall_cnt`=10; a new start clears it to 0.
